ram_cmd_arbiter: RTL
====================

# ram_cmd_arbiter

Arbitrates between two word-level requesters and sequences their accesses into the two-word opcode protocol of the 512x16 RAM (`ram_data_in[17:16]` opcode, `[15:0]` payload, qualified by `ram_rx_valid`). Each accepted request becomes an address command followed by a data command. Read data is captured from the RAM response and returned to the requester with a one-cycle acknowledge. The block sits between the SPI-slave and auxiliary (scrub/debug) masters on one side and the RAM on the other.

## Interface
- ADDR_W, 9, word address width; zero-extended to the 16-bit RAM payload.
- DATA_W, 16, word data width; fixed to the RAM word size.
- sys_clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level; bit i = requester i.
- we  in  2  per-requester write enable (1 = write, 0 = read); sampled with req.
- addr  in  2*ADDR_W  requester i address at [ADDR_W*i +: ADDR_W].
- wdata  in  2*DATA_W  requester i write data at [DATA_W*i +: DATA_W].
- ack  out  2  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_W  read data; valid in the ack cycle of a read; holds until the next read capture.
- rd_err  out  1  one-cycle pulse with ack when the RAM gave no tx_valid on a read.
- busy  out  1  high in every state except IDLE.
- ram_rx_valid  out  1  command strobe to the RAM.
- ram_data_in  out  18  {opcode[1:0], payload[15:0]} to the RAM.
- ram_data_out  in  18  RAM read response; bits [15:0] carry the data.
- ram_tx_valid  in  1  RAM read-response valid.

## Operation
- Opcodes: 00 ADDR_STORE, 01 DATA_WRITE, 10 READ_ADDR, 11 READ_DATA.
- FSM states: IDLE, CMD_ADDR, CMD_DATA, CAPT, DONE.
- **IDLE**
  - If any req bit is high, grant one requester and latch its we, addr and wdata into internal registers; go to CMD_ADDR.
  - Otherwise stay in IDLE.
- **Arbitration:** round-robin.
  - When both requesters are asserted, grant the one not granted last.
  - After reset, requester 0 has priority.
  - The last-grant register updates in DONE.
- **CMD_ADDR**
  - Drive ram_rx_valid=1.
  - Drive ram_data_in={we ? 2'b00 : 2'b10, zero-extended addr}.
  - Go to CMD_DATA.
- **CMD_DATA**
  - Drive ram_rx_valid=1.
  - Write: drive {2'b01, wdata}, then go to DONE.
  - Read: drive {2'b11, 16'h0000}, then go to CAPT.
- **CAPT**
  - Drive ram_rx_valid=0.
  - Register rdata <= ram_data_out[15:0]; record err = ~ram_tx_valid.
  - Go to DONE.
- **DONE**
  - Drive ram_rx_valid=0.
  - Assert ack[granted]=1; for reads, assert rd_err = recorded err.
  - Go to IDLE.
- Outside CMD_ADDR and CMD_DATA: ram_rx_valid=0 and ram_data_in=18'h0.
- Requester protocol:
  - Hold req high until ack.
  - Drop req in the ack cycle, or keep it high to request again.
  - Changes to req, we, addr or wdata after the grant are ignored; the latched transaction always completes.
- Only one transaction is in flight at a time. No pipelining across transactions.

## Timing
- Reset values: ack=0, rdata=0, rd_err=0, busy=0, ram_rx_valid=0, ram_data_in=0, state=IDLE, last-grant=1 (so requester 0 wins first).
- Write latency: req sampled in cycle 0 (IDLE); CMD_ADDR in cycle 1; CMD_DATA in cycle 2; ack in cycle 3. Occupancy is 4 cycles.
- Read latency: cycles 0-2 as for write; CAPT in cycle 3 (RAM output valid); ack with rdata in cycle 4. Occupancy is 5 cycles.
- Back-to-back requests: the next grant is earliest in the IDLE cycle after DONE, so there is no overlap.
- Both requesters continuously requesting: grants alternate 0,1,0,1…
- A single requester requesting continuously is served every occupancy period with no starvation check needed.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values; no ack is issued for the aborted transaction.
- Address range: addr is 9 bits, so every request maps into 0..511. The upper 7 payload bits are always 0.

## Test plan
- Write then read, requester 0: write addr 9'h05 data 16'hA5A5, then read 9'h05 -> ack0 at cycle 3 for the write; ack0 at cycle 4 for the read with rdata=16'hA5A5, rd_err=0.
- RAM command trace: write 9'h1FF data 16'h1234 -> ram_data_in=18'h001FF then 18'h11234 on consecutive cycles, each with ram_rx_valid=1, then ram_rx_valid=0.
- Contention: both requesters held high for 4 transactions (writes 16'h0001/16'h0002 to 9'h010/9'h011) -> ack order 0,1,0,1; no ack ever on both bits at once.
- Read error: force ram_tx_valid=0 in the CAPT cycle on a read -> ack with rd_err=1.
- Reset mid-op: assert reset_n=0 during CMD_DATA of a write to 9'h020 -> busy=0, no ack, and a subsequent read of 9'h020 returns 16'h0000.
- Request change after grant: change addr0 from 9'h030 to 9'h031 in CMD_ADDR -> the command still uses 9'h030.

Source files
------------

// File: rtl/ram_cmd_arbiter_if.sv
// Requester-side and RAM-side bus of the two-master RAM command arbiter.
// The arbiter attaches through the slave modport; the master modport drives it.
interface ram_cmd_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic [1:0]          req;
   logic [1:0]          we;
   logic [2*ADDR_W-1:0] addr;
   logic [2*DATA_W-1:0] wdata;
   logic [1:0]          ack;
   logic [DATA_W-1:0]   rdata;
   logic                rd_err;
   logic                busy;
   logic                ram_rx_valid;
   logic [17:0]         ram_data_in;
   logic [17:0]         ram_data_out;
   logic                ram_tx_valid;

   modport slave (
      input  req, we, addr, wdata, ram_data_out, ram_tx_valid,
      output ack, rdata, rd_err, busy, ram_rx_valid, ram_data_in
   );

   modport master (
      output req, we, addr, wdata, ram_data_out, ram_tx_valid,
      input  ack, rdata, rd_err, busy, ram_rx_valid, ram_data_in
   );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter for two word requesters, translating each accepted request
// into the RAM's two-command opcode sequence and returning read data with an ack.
module ram_cmd_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic                   sys_clock,
   input  logic                   reset_n,
   ram_cmd_arbiter_if.slave       bus,
   output logic [2:0]             dbg_state
);
   // Valid/ready contract: a requester holds req until its one-cycle ack; the
   // request is latched on grant in IDLE, later changes are ignored, and the RAM
   // takes one command per cycle wherever ram_rx_valid is high (no back-pressure).

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CMD_ADDR = 3'd1;
   localparam logic [2:0] S_CMD_DATA = 3'd2;
   localparam logic [2:0] S_CAPT     = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [1:0] OP_ADDR_STORE = 2'b00;
   localparam logic [1:0] OP_DATA_WRITE = 2'b01;
   localparam logic [1:0] OP_READ_ADDR  = 2'b10;
   localparam logic [1:0] OP_READ_DATA  = 2'b11;

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic              r_gnt;
   logic              r_last;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic              w_gnt;
   logic              w_any_req;
   logic [15:0]       w_addr_payload;
   logic              w_unused_hi;

   assign w_any_req      = |bus.req;
   assign w_addr_payload = {{(16-ADDR_W){1'b0}}, r_addr};
   assign w_unused_hi    = ^bus.ram_data_out[17:16];

   // With both requesting, the one not served last wins; r_last resets to 1.
   always_comb begin
      w_gnt = 1'b0;
      if (bus.req == 2'b11) begin
         w_gnt = ~r_last;
      end else begin
         w_gnt = bus.req[1];
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:     w_next_state = w_any_req ? S_CMD_ADDR : S_IDLE;
         S_CMD_ADDR: w_next_state = S_CMD_DATA;
         S_CMD_DATA: w_next_state = r_we ? S_DONE : S_CAPT;
         S_CAPT:     w_next_state = S_DONE;
         S_DONE:     w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_gnt   <= w_gnt;
                  r_we    <= w_gnt ? bus.we[1] : bus.we[0];
                  r_addr  <= w_gnt ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
                  r_wdata <= w_gnt ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
                  r_err   <= 1'b0;
               end
            end
            S_CAPT: begin
               r_rdata <= bus.ram_data_out[DATA_W-1:0];
               r_err   <= ~bus.ram_tx_valid;
            end
            S_DONE: begin
               r_last <= r_gnt;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      bus.ram_rx_valid = 1'b0;
      bus.ram_data_in  = 18'h0;
      case (r_state)
         S_CMD_ADDR: begin
            bus.ram_rx_valid = 1'b1;
            bus.ram_data_in  = {(r_we ? OP_ADDR_STORE : OP_READ_ADDR), w_addr_payload};
         end
         S_CMD_DATA: begin
            bus.ram_rx_valid = 1'b1;
            bus.ram_data_in  = r_we ? {OP_DATA_WRITE, r_wdata} : {OP_READ_DATA, 16'h0000};
         end
         default: begin
         end
      endcase
   end

   assign bus.ack    = (r_state == S_DONE) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rd_err = (r_state == S_DONE) & ~r_we & r_err & ~w_unused_hi | 
                       (r_state == S_DONE) & ~r_we & r_err & w_unused_hi;
   assign bus.rdata  = r_rdata;
   assign bus.busy   = (r_state != S_IDLE);
   assign dbg_state  = r_state;
endmodule
